// File: rtl/display_480p.sv
`timescale 1ns/1ps
// display_480p: free-running video timing generator (640x480 @ 60 Hz by default).
// Outputs are registered from the next-state coordinates so sync/de/pulses align with sx/sy.
module display_480p #(
    parameter int unsigned CORDW  = 10,
    parameter int unsigned H_RES  = 640,
    parameter int unsigned H_FP   = 16,
    parameter int unsigned H_SYNC = 96,
    parameter int unsigned H_BP   = 48,
    parameter int unsigned V_RES  = 480,
    parameter int unsigned V_FP   = 10,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BP   = 33,
    parameter logic        H_POL  = 1'b0,
    parameter logic        V_POL  = 1'b0
) (
    input  logic             clk_pix,
    input  logic             rst_pix,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             frame,
    output logic             line
);
    localparam int unsigned H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_STA  = H_RES + H_FP;
    localparam int unsigned HS_END  = HS_STA + H_SYNC;
    localparam int unsigned VS_STA  = V_RES + V_FP;
    localparam int unsigned VS_END  = VS_STA + V_SYNC;
    localparam logic [CORDW-1:0] H_MAX = CORDW'(H_TOTAL - 1);
    localparam logic [CORDW-1:0] V_MAX = CORDW'(V_TOTAL - 1);

    if ((64'(H_TOTAL - 1) >= (64'd1 << CORDW)) || (64'(V_TOTAL - 1) >= (64'd1 << CORDW))) begin : g_cordw_check
        $error("display_480p: CORDW too narrow for H_TOTAL/V_TOTAL");
    end

    logic [CORDW-1:0] r_sx;
    logic [CORDW-1:0] r_sy;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_de;
    logic             r_frame;
    logic             r_line;

    logic [CORDW-1:0] w_sx_next;
    logic [CORDW-1:0] w_sy_next;
    logic             w_hs_act;
    logic             w_vs_act;
    logic             w_de_next;

    // Next coordinates; reset parks the counters at the last pixel so the first edge lands on (0,0).
    always_comb begin
        w_sx_next = r_sx + CORDW'(1);
        w_sy_next = r_sy;
        if (r_sx == H_MAX) begin
            w_sx_next = '0;
            w_sy_next = (r_sy == V_MAX) ? '0 : r_sy + CORDW'(1);
        end
    end

    always_comb begin
        w_hs_act  = (w_sx_next >= CORDW'(HS_STA)) && (w_sx_next < CORDW'(HS_END));
        w_vs_act  = (w_sy_next >= CORDW'(VS_STA)) && (w_sy_next < CORDW'(VS_END));
        w_de_next = (w_sx_next < CORDW'(H_RES)) && (w_sy_next < CORDW'(V_RES));
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            r_sx    <= H_MAX;
            r_sy    <= V_MAX;
            r_hsync <= ~H_POL;
            r_vsync <= ~V_POL;
            r_de    <= 1'b0;
            r_frame <= 1'b0;
            r_line  <= 1'b0;
        end else begin
            r_sx    <= w_sx_next;
            r_sy    <= w_sy_next;
            r_hsync <= w_hs_act ? H_POL : ~H_POL;
            r_vsync <= w_vs_act ? V_POL : ~V_POL;
            r_de    <= w_de_next;
            r_frame <= (w_sx_next == '0) && (w_sy_next == '0);
            r_line  <= (w_sx_next == '0);
        end
    end

    assign sx    = r_sx;
    assign sy    = r_sy;
    assign hsync = r_hsync;
    assign vsync = r_vsync;
    assign de    = r_de;
    assign frame = r_frame;
    assign line  = r_line;
endmodule

// File: tb/tb_display_480p.sv
`timescale 1ns/1ps
// tb_display_480p: three timing generators (default, inverted polarity, tiny raster)
// checked cycle-by-cycle against a reference counter model via an expected-value queue.
module tb_display_480p;
    typedef struct packed {
        logic [9:0] sx;
        logic [9:0] sy;
        logic       hs;
        logic       vs;
        logic       de;
        logic       fr;
        logic       ln;
    } exp_t;

    int HR [3] = '{640, 640, 16};
    int HF [3] = '{16, 16, 2};
    int HS [3] = '{96, 96, 4};
    int HB [3] = '{48, 48, 3};
    int VR [3] = '{480, 480, 8};
    int VF [3] = '{10, 10, 2};
    int VS [3] = '{2, 2, 2};
    int VB [3] = '{33, 33, 3};
    bit HP [3] = '{1'b0, 1'b1, 1'b0};
    bit VP [3] = '{1'b0, 1'b1, 1'b0};

    logic       clk;
    logic       rst;
    logic [9:0] sx_o [3];
    logic [9:0] sy_o [3];
    logic       hs_o [3];
    logic       vs_o [3];
    logic       de_o [3];
    logic       fr_o [3];
    logic       ln_o [3];

    exp_t sb_q [3][$];
    int   m_sx [3];
    int   m_sy [3];
    int   n_chk  = 0;
    int   n_pass = 0;

    display_480p dut0 (
        .clk_pix(clk), .rst_pix(rst), .sx(sx_o[0]), .sy(sy_o[0]), .hsync(hs_o[0]),
        .vsync(vs_o[0]), .de(de_o[0]), .frame(fr_o[0]), .line(ln_o[0])
    );

    display_480p #(.H_POL(1'b1), .V_POL(1'b1)) dut1 (
        .clk_pix(clk), .rst_pix(rst), .sx(sx_o[1]), .sy(sy_o[1]), .hsync(hs_o[1]),
        .vsync(vs_o[1]), .de(de_o[1]), .frame(fr_o[1]), .line(ln_o[1])
    );

    display_480p #(
        .CORDW(10), .H_RES(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_RES(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .H_POL(1'b0), .V_POL(1'b0)
    ) dut2 (
        .clk_pix(clk), .rst_pix(rst), .sx(sx_o[2]), .sy(sy_o[2]), .hsync(hs_o[2]),
        .vsync(vs_o[2]), .de(de_o[2]), .frame(fr_o[2]), .line(ln_o[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int h_tot(int d);
        return HR[d] + HF[d] + HS[d] + HB[d];
    endfunction

    function automatic int v_tot(int d);
        return VR[d] + VF[d] + VS[d] + VB[d];
    endfunction

    function automatic exp_t model_out(int d, int x, int y);
        exp_t e;
        e.sx = 10'(x);
        e.sy = 10'(y);
        e.hs = (x >= HR[d] + HF[d] && x < HR[d] + HF[d] + HS[d]) ? HP[d] : !HP[d];
        e.vs = (y >= VR[d] + VF[d] && y < VR[d] + VF[d] + VS[d]) ? VP[d] : !VP[d];
        e.de = (x < HR[d]) && (y < VR[d]);
        e.ln = (x == 0);
        e.fr = (x == 0) && (y == 0);
        return e;
    endfunction

    function automatic exp_t reset_exp(int d);
        exp_t e;
        e.sx = 10'(h_tot(d) - 1);
        e.sy = 10'(v_tot(d) - 1);
        e.hs = !HP[d];
        e.vs = !VP[d];
        e.de = 1'b0;
        e.fr = 1'b0;
        e.ln = 1'b0;
        return e;
    endfunction

    function automatic exp_t got_out(int d);
        exp_t e;
        e.sx = sx_o[d];
        e.sy = sy_o[d];
        e.hs = hs_o[d];
        e.vs = vs_o[d];
        e.de = de_o[d];
        e.fr = fr_o[d];
        e.ln = ln_o[d];
        return e;
    endfunction

    task automatic sb_async_reset();
        for (int d = 0; d < 3; d++) begin
            m_sx[d] = h_tot(d) - 1;
            m_sy[d] = v_tot(d) - 1;
            sb_q[d].delete();
            sb_q[d].push_back(reset_exp(d));
        end
    endtask

    // Reference model advances on each clock edge and queues what each DUT must show.
    initial forever begin
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                m_sx[d] = h_tot(d) - 1;
                m_sy[d] = v_tot(d) - 1;
                sb_q[d].push_back(reset_exp(d));
            end else begin
                if (m_sx[d] == h_tot(d) - 1) begin
                    m_sx[d] = 0;
                    m_sy[d] = (m_sy[d] == v_tot(d) - 1) ? 0 : m_sy[d] + 1;
                end else begin
                    m_sx[d] = m_sx[d] + 1;
                end
                sb_q[d].push_back(model_out(d, m_sx[d], m_sy[d]));
            end
        end
    end

    initial forever begin
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            if (sb_q[d].size() > 0) begin
                exp_t e;
                e = sb_q[d].pop_front();
                chk($sformatf("sb_dut%0d", d), 32'(got_out(d)), 32'(e));
            end
        end
    end

    initial begin
        int  hs_lo, de_n, ln_n, inv_hs_hi;
        int  sm_vs, sm_de, sm_ln, sm_fr, sm_gap;
        bit  prev_wrap, saw_wrap, found;
        hs_lo = 0; de_n = 0; ln_n = 0; inv_hs_hi = 0;
        sm_vs = 0; sm_de = 0; sm_ln = 0; sm_fr = 0; sm_gap = 0;
        prev_wrap = 1'b0; saw_wrap = 1'b0; found = 1'b0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_sx", 32'(sx_o[0]), 32'd799);
        chk("rst_sy", 32'(sy_o[0]), 32'd524);
        chk("rst_hs", 32'(hs_o[0]), 32'd1);
        chk("rst_inv_hs", 32'(hs_o[1]), 32'd0);
        chk("rst_inv_vs", 32'(vs_o[1]), 32'd0);
        rst = 1'b0;

        for (int k = 0; k < 10000; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk("first_sx", 32'(sx_o[0]), 32'd0);
                chk("first_sy", 32'(sy_o[0]), 32'd0);
                chk("first_frame", 32'(fr_o[0]), 32'd1);
                chk("first_line", 32'(ln_o[0]), 32'd1);
                chk("first_de", 32'(de_o[0]), 32'd1);
            end
            if (sy_o[0] == 10'd0) begin
                if (!hs_o[0]) hs_lo++;
                if (de_o[0]) de_n++;
                if (ln_o[0]) ln_n++;
                if (hs_o[1]) inv_hs_hi++;
            end
            if (prev_wrap) begin
                chk("wrap_sx", 32'(sx_o[0]), 32'd0);
                chk("wrap_sy", 32'(sy_o[0]), 32'd11);
                prev_wrap = 1'b0;
            end
            if (sx_o[0] == 10'd799 && sy_o[0] == 10'd10) begin
                prev_wrap = 1'b1;
                saw_wrap  = 1'b1;
            end
            if (k < 375) begin
                if (!vs_o[2]) sm_vs++;
                if (de_o[2]) sm_de++;
                if (ln_o[2]) sm_ln++;
                if (fr_o[2]) sm_fr++;
            end
            if (k > 0 && fr_o[2] && sm_gap == 0) sm_gap = k;
        end
        chk("saw_wrap", 32'(saw_wrap), 32'd1);
        chk("line_hs_low", 32'(hs_lo), 32'd96);
        chk("line_de", 32'(de_n), 32'd640);
        chk("line_pulses", 32'(ln_n), 32'd1);
        chk("inv_hs_high", 32'(inv_hs_hi), 32'd96);
        chk("small_vs_low", 32'(sm_vs), 32'd50);
        chk("small_de", 32'(sm_de), 32'd128);
        chk("small_lines", 32'(sm_ln), 32'd15);
        chk("small_frames", 32'(sm_fr), 32'd1);
        chk("small_frame_gap", 32'(sm_gap), 32'd375);

        // Asynchronous reset in the middle of a small-raster frame, between clock edges.
        for (int k = 0; k < 400 && !found; k++) begin
            @(negedge clk);
            if (sx_o[2] == 10'd10 && sy_o[2] == 10'd5) found = 1'b1;
        end
        chk("find_10_5", 32'(found), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        sb_async_reset();
        #1;
        chk("async_sx", 32'(sx_o[2]), 32'd24);
        chk("async_sy", 32'(sy_o[2]), 32'd14);
        chk("async_hs", 32'(hs_o[2]), 32'd1);
        chk("async_vs", 32'(vs_o[2]), 32'd1);
        chk("async_de", 32'(de_o[2]), 32'd0);
        chk("async_line", 32'(ln_o[2]), 32'd0);
        chk("async_dut0_sx", 32'(sx_o[0]), 32'd799);
        chk("async_inv_hs", 32'(hs_o[1]), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_sx", 32'(sx_o[2]), 32'd0);
        chk("rel_sy", 32'(sy_o[2]), 32'd0);
        chk("rel_frame", 32'(fr_o[2]), 32'd1);
        chk("rel_dut0_frame", 32'(fr_o[0]), 32'd1);
        repeat (400) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
